// File: rtl/embertrail_issue_seq.sv
// Embertrail packet sequencer: latches a LANES-slot packet, walks it through the
// pipeline stages and resolves the next PC, the data-memory handshake and the stack pointer.
module embertrail_issue_seq #(
    parameter int          PC_W     = 16,
    parameter int          LANES    = 2,
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'h00FF
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic [16*LANES-1:0]   iIR,
    input  logic                  iIRValid,
    input  logic                  iMemReady,
    input  logic                  iCmpResult,
    output logic [PC_W-1:0]       oInstAddrBus,
    output logic [5:0]            oStage,
    output logic [LANES-1:0]      oLaneValid,
    output logic [LANES-1:0]      oRegWriteEn,
    output logic                  oMemReq,
    output logic [LANES-1:0]      oMemLane,
    output logic [LANES-1:0]      oMemRW,
    output logic [PC_W-1:0]       oStackAddr,
    output logic [PC_W-1:0]       oStackPtr,
    output logic [PC_W-1:0]       oExtOperand,
    output logic                  oIllegal
);
    // Handshakes: a packet is taken when iIRValid is high in FETCH; oMemReq stays high in MEM
    // until iMemReady is seen high, and every participating lane completes on that same edge.
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_MEM, S_WB
    } state_t;

    // Opcode class tables, indexed by the 4-bit opcode.
    localparam logic [15:0] WRITE_CLASS = 16'h69FF;
    localparam logic [15:0] MEM_CLASS   = 16'h0E80;
    localparam logic [15:0] STORE_CLASS = 16'h0600;
    localparam logic [3:0]  OP_LDA  = 4'd8;
    localparam logic [3:0]  OP_PUSH = 4'd10;
    localparam logic [3:0]  OP_POP  = 4'd11;
    localparam logic [3:0]  OP_BEQ  = 4'd12;

    state_t               state;
    state_t               nextState;
    logic [16*LANES-1:0]  irQ;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      sp;
    logic [PC_W-1:0]      slot1;
    logic [PC_W-1:0]      pcInc;
    logic [PC_W-1:0]      extOperand;
    logic                 illegalQ;
    logic [3:0]           op [LANES];
    logic                 live;
    logic                 slot0Ext;
    logic                 anyMem;
    logic                 push0;
    logic                 pop0;
    logic                 branchTaken;
    logic [LANES-1:0]     laneValid;
    logic [LANES-1:0]     laneIllegal;
    logic [LANES-1:0]     memLane;
    logic [LANES-1:0]     memStore;
    logic [LANES-1:0]     writeLane;
    logic                 unusedIrBits;

    generate
        if (LANES >= 2) begin : gSlot1
            assign slot1 = irQ[16+PC_W-1:16];
        end else begin : gNoSlot1
            assign slot1 = '0;
        end
    endgenerate

    assign unusedIrBits = ^irQ;

    always_comb begin
        live        = (state != S_FETCH);
        laneValid   = '0;
        laneIllegal = '0;
        memLane     = '0;
        memStore    = '0;
        writeLane   = '0;
        for (int k = 0; k < LANES; k++) begin
            op[k] = irQ[16*k +: 4];
        end
        slot0Ext = (op[0] == OP_LDA) || (op[0] == OP_BEQ);
        if (live) begin
            laneValid[0] = 1'b1;
            if (!slot0Ext && irQ[15]) begin
                laneValid = '1;
            end
        end
        // Stack ops only have an address path in lane 0; elsewhere they collapse to NOPs.
        for (int k = 0; k < LANES; k++) begin
            laneIllegal[k] = (k != 0) && laneValid[k] && ((op[k] == OP_PUSH) || (op[k] == OP_POP));
            memLane[k]     = laneValid[k] && !laneIllegal[k] && MEM_CLASS[op[k]];
            memStore[k]    = memLane[k] && STORE_CLASS[op[k]];
            writeLane[k]   = laneValid[k] && !laneIllegal[k] && WRITE_CLASS[op[k]];
        end
        anyMem      = |memLane;
        push0       = live && (op[0] == OP_PUSH);
        pop0        = live && (op[0] == OP_POP);
        extOperand  = (live && slot0Ext) ? slot1 : '0;
        pcInc       = slot0Ext ? PC_W'(2) : (irQ[15] ? PC_W'(LANES) : PC_W'(1));
        branchTaken = (op[0] == OP_BEQ) && iCmpResult;
    end

    always_comb begin
        nextState = state;
        oStage    = 6'b000000;
        case (state)
            S_FETCH: begin
                oStage = 6'b000001;
                if (iIRValid) nextState = S_DECODE;
            end
            S_DECODE: begin
                oStage    = 6'b000010;
                nextState = S_OPERAND;
            end
            S_OPERAND: begin
                oStage    = 6'b000100;
                nextState = S_EXEC;
            end
            S_EXEC: begin
                oStage    = 6'b001000;
                nextState = anyMem ? S_MEM : S_WB;
            end
            S_MEM: begin
                oStage = 6'b010000;
                if (iMemReady) nextState = S_WB;
            end
            S_WB: begin
                oStage    = 6'b100000;
                nextState = S_FETCH;
            end
            default: nextState = S_FETCH;
        endcase
    end

    assign oInstAddrBus = pc;
    assign oLaneValid   = laneValid;
    assign oRegWriteEn  = (state == S_WB) ? writeLane : '0;
    assign oMemReq      = (state == S_MEM);
    assign oMemLane     = memLane;
    assign oMemRW       = memStore;
    assign oStackAddr   = push0 ? (sp - PC_W'(1)) : sp;
    assign oStackPtr    = sp;
    assign oExtOperand  = extOperand;
    assign oIllegal     = illegalQ;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state    <= S_FETCH;
            pc       <= PC_RESET[PC_W-1:0];
            sp       <= SP_RESET[PC_W-1:0];
            irQ      <= '0;
            illegalQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_FETCH && iIRValid) irQ <= iIR;
            if (state == S_DECODE && |laneIllegal) illegalQ <= 1'b1;
            if (state == S_MEM && iMemReady) begin
                if (push0) sp <= sp - PC_W'(1);
                else if (pop0) sp <= sp + PC_W'(1);
            end
            if (state == S_WB) pc <= branchTaken ? slot1 : (pc + pcInc);
        end
    end
endmodule

// File: doc/embertrail_issue_seq.md
# embertrail_issue_seq

Parametrised packet sequencer for the Embertrail core, the successor to the fixed dual-issue stage counter inside the control unit. It fetches a LANES-slot instruction packet, steps it through DECODE/OPERAND/EXEC/(MEM)/WB, and resolves the next PC: sequential, extended-operand, or taken branch. It also waits on instruction- and data-memory handshakes and owns the stack pointer. Lane decoders and ALUs consume its stage strobes and per-lane masks.

## Interface
- PC_W, 16, width of PC, stack pointer and extended operand (8..16)
- LANES, 2, issue slots per packet (1..4); slot k = iIR[16k+15:16k]
- PC_RESET, 0, PC value after reset
- SP_RESET, 16'h00FF, stack pointer value after reset
- iClock  in  1  clock; all state on rising edge
- iReset  in  1  reset, synchronous, active-high
- iIR  in  16*LANES  packet from instruction memory
- iIRValid  in  1  iIR valid for oInstAddrBus
- iMemReady  in  1  data memory completes the current request
- iCmpResult  in  1  lane-0 ALU compare result (bit 0 of ALU result)
- oInstAddrBus  out  PC_W  current PC
- oStage  out  6  one-hot {WB,MEM,EXEC,OPERAND,DECODE,FETCH}
- oLaneValid  out  LANES  lanes holding a live instruction
- oRegWriteEn  out  LANES  register write strobes, high only in WB
- oMemReq  out  1  data request, held through MEM
- oMemLane  out  LANES  lanes participating in the request
- oMemRW  out  LANES  1 = store per lane
- oStackAddr  out  PC_W  stack address for lane 0
- oStackPtr  out  PC_W  architectural stack pointer
- oExtOperand  out  PC_W  slot-1 payload of an extended packet
- oIllegal  out  1  sticky: PUSH/POP decoded outside lane 0

## Operation
- Opcode = slot[3:0]. Write-class: 0-8, 11, 13, 14. Memory: 7 LDR, 9 STR (store), 10 PUSH (store), 11 POP. Extended: 8 LDA, 12 BEQ. NOP: 15.
- Lane validity: lane 0 is always valid. If slot0 is extended, lane 1 carries the operand, oExtOperand = slot1[PC_W-1:0], and lanes 1..LANES-1 are invalid. Otherwise, if slot0[15]=1, all lanes are valid. Otherwise only lane 0 is valid.
- PC increment: extended = 2; slot0[15] = LANES; else 1. Arithmetic is mod 2^PC_W.
- FSM states: FETCH -> DECODE -> OPERAND -> EXEC -> (MEM if any valid lane is a memory op) -> WB -> FETCH.
- FETCH holds until iIRValid=1. iIR is then latched; later changes on iIR are ignored.
- MEM holds oMemReq=1 until iMemReady=1, then goes to WB. All lanes complete together.
- WB: oRegWriteEn = valid & write-class. Branch taken if lane 0 is BEQ and iCmpResult=1; then PC <= oExtOperand, else PC <= PC + increment.
- Stack: PUSH uses address SP-1 and sets SP <= SP-1 on iMemReady. POP uses address SP and sets SP <= SP+1 on iMemReady. SP wraps mod 2^PC_W.
- PUSH/POP in lane ≥1: that lane is treated as a NOP (no mem, no write) and oIllegal is set. oIllegal clears only on reset.

## Timing
- Reset values: oStage=000001, PC=PC_RESET, SP=SP_RESET. All of oLaneValid, oRegWriteEn, oMemReq, oMemLane, oMemRW, oExtOperand and oIllegal are 0.
- Latency: 5 cycles per packet without memory access. With memory: 6 + (cycles iMemReady is low in MEM).
- oInstAddrBus changes only at the WB->FETCH edge.
- oLaneValid, oMemLane, oMemRW and oExtOperand are valid from DECODE through WB. They are 0 in FETCH.
- iMemReady is sampled only in MEM and ignored elsewhere. iIRValid is sampled only in FETCH. iCmpResult is sampled only in WB.
- Reset asserted in any state, including MEM with oMemReq high: on the next edge the block is in FETCH with reset values, and no SP update or write strobe is issued.

## Test plan
- PC=0, packet slot0=ADDR, slot0[15]=0, iIRValid=1 -> oRegWriteEn=01 only in cycle 5; PC=1 at the next FETCH.
- LANES=2, slot0=ORI with [15]=1, slot1=SHIFTL -> oLaneValid=11, oRegWriteEn=11 in WB; PC 0x0010 -> 0x0012.
- LDR in lane 0, iMemReady low for 3 MEM cycles -> oMemReq high 4 cycles, write strobe one cycle later; total 9 cycles.
- BEQ in slot0 with slot1=0x0040, iCmpResult=1 -> PC=0x0040. Same with iCmpResult=0 -> PC+2. Lane 1 never valid.
- PUSH with SP=0x00FF -> oStackAddr=0x00FE, SP=0x00FE after iMemReady. POP from SP=0xFFFF -> SP=0x0000. PUSH in lane 1 -> NOP and oIllegal=1.
- PC=0xFFFF single-issue -> PC=0x0000. iReset during MEM -> FETCH, PC=0, SP unchanged from SP_RESET, no strobes.
